// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: branch codes, NOP, opcode field, fetch states
//
// Purpose: common definitions used by the fetch stage and the ID decode logic.
// Ports:   none (package).
package cpu_pkg;

    // Branch-type codes produced by ID decode.
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    // All-zero instruction decodes as opcode 0, which ID treats as a NOP.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Opcode field position within an instruction word.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/branch_condition_unit.sv
// rtl/branch_condition_unit.sv - combinational BEZ/BNE/JMP resolution and target computation
//
// Purpose: decides whether a branch candidate is taken and computes its target
//          br_pc + (sext(br_imm) << 2), wrapping modulo 2^ADDR_W.
// Ports:
//   br_valid     in   candidate present this cycle
//   branch_type  in   BR_NONE / BR_BEZ / BR_BNE / BR_JMP
//   br_reg1/2    in   source operand values
//   br_imm       in   signed word offset
//   br_pc        in   pc+4 of the branch instruction
//   taken        out  branch redirects the PC
//   target       out  redirect address
module branch_condition_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              br_valid,
    input  logic [1:0]        branch_type,
    input  logic [31:0]       br_reg1,
    input  logic [31:0]       br_reg2,
    input  logic [15:0]       br_imm,
    input  logic [ADDR_W-1:0] br_pc,
    output logic              taken,
    output logic [ADDR_W-1:0] target
);

    logic              cond;
    logic [ADDR_W-1:0] offset;

    always_comb begin
        cond = 1'b0;
        case (branch_type)
            BR_BEZ:  cond = (br_reg1 == 32'd0);
            BR_BNE:  cond = (br_reg1 != br_reg2);
            BR_JMP:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign offset = {{(ADDR_W-16){br_imm[15]}}, br_imm} << 2;
    assign target = br_pc + offset;
    assign taken  = br_valid & cond;

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage with IF/ID register, hold buffer and branch redirect
//
// Purpose: owns the PC, fetches over a req/ack handshake, presents {pc+4, instr} to ID,
//          and squashes wrong-path fetches on taken branches.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   freeze                       hazard stall: hold PC and IF/ID
//   br_valid, branch_type,
//   br_reg1, br_reg2, br_imm,
//   br_pc                        branch candidate from ID
//   imem_req, imem_addr          fetch request, held until imem_ack
//   imem_ack, imem_rdata         fetch completion and data
//   if_id_pc, if_id_instr,
//   if_id_valid                  IF/ID register contents
//   flush                        one-cycle pulse after a taken branch
module instruction_fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               br_valid,
    input  logic [1:0]         branch_type,
    input  logic [31:0]        br_reg1,
    input  logic [31:0]        br_reg2,
    input  logic [15:0]        br_imm,
    input  logic [ADDR_W-1:0]  br_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic               flush
);

    localparam logic [ADDR_W-1:0]  STEP = ADDR_W'(PC_STEP);
    localparam logic [INSTR_W-1:0] NOP  = INSTR_W'(NOP_INSTR);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic               hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic               flush_q, flush_d;

    logic               bcu_taken;
    logic [ADDR_W-1:0]  bcu_target;
    logic               taken;
    logic               ack_fire;

    branch_condition_unit #(.ADDR_W(ADDR_W)) u_bcu (
        .br_valid    (br_valid),
        .branch_type (branch_type),
        .br_reg1     (br_reg1),
        .br_reg2     (br_reg2),
        .br_imm      (br_imm),
        .br_pc       (br_pc),
        .taken       (bcu_taken),
        .target      (bcu_target)
    );

    // A stall freezes ID, so its branch decision is not yet final.
    assign taken    = bcu_taken & ~freeze;
    // Acks only count while a real request is on the bus in FETCH.
    assign ack_fire = (state_q == ST_FETCH) & req_q & imem_ack;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_d         = req_q;
        addr_d        = addr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        hold_valid_d  = hold_valid_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        flush_d       = 1'b0;

        // Any unstalled cycle without fresh data presents a bubble.
        if (!freeze) begin
            if_id_instr_d = NOP;
            if_id_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end
            ST_FETCH: begin
                if (ack_fire) begin
                    pc_d = pc_q + STEP;
                    if (!freeze) begin
                        if_id_pc_d    = pc_q + STEP;
                        if_id_instr_d = imem_rdata;
                        if_id_valid_d = 1'b1;
                        req_d         = 1'b1;
                        addr_d        = pc_q + STEP;
                    end else begin
                        // Park the word; stop fetching until ID can take it.
                        hold_valid_d = 1'b1;
                        hold_pc_d    = pc_q + STEP;
                        hold_instr_d = imem_rdata;
                        req_d        = 1'b0;
                    end
                end else if (hold_valid_q && !freeze) begin
                    if_id_pc_d    = hold_pc_q;
                    if_id_instr_d = hold_instr_q;
                    if_id_valid_d = 1'b1;
                    hold_valid_d  = 1'b0;
                    req_d         = 1'b1;
                    addr_d        = pc_q;
                end
            end
            ST_DISCARD: begin
                // Wrong-path word arrives and is dropped; pc already holds the target.
                if (imem_ack) begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (taken) begin
            pc_d          = bcu_target;
            if_id_instr_d = NOP;
            if_id_valid_d = 1'b0;
            hold_valid_d  = 1'b0;
            flush_d       = 1'b1;
            if (req_q && !imem_ack &&
                (state_q == ST_FETCH || state_q == ST_DISCARD)) begin
                // The bus request cannot be withdrawn; wait out its ack.
                state_d = ST_DISCARD;
                req_d   = req_q;
                addr_d  = addr_q;
            end else begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                addr_d  = bcu_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            req_q         <= 1'b0;
            addr_q        <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP;
            if_id_valid_q <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_pc_q     <= '0;
            hold_instr_q  <= NOP;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            hold_valid_q  <= hold_valid_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
            flush_q       <= flush_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign flush       = flush_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - self-checking bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        br_valid;
    logic [1:0]  branch_type;
    logic [31:0] br_reg1, br_reg2;
    logic [15:0] br_imm;
    logic [31:0] br_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        flush;

    instruction_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .br_valid    (br_valid),
        .branch_type (branch_type),
        .br_reg1     (br_reg1),
        .br_reg2     (br_reg2),
        .br_imm      (br_imm),
        .br_pc       (br_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Memory model state
    bit mem_auto;
    bit rand_lat;
    int lat;
    int cnt;

    typedef struct {
        logic        frz;
        logic        bv;
        logic [1:0]  bt;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [15:0] imm;
        logic [31:0] bpc;
        logic        exp_flush;
        logic [31:0] exp_tgt;
    } br_vec_t;

    br_vec_t tbl[10];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[17:2]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mem_update();
        if (mem_auto) begin
            if (imem_req) begin
                cnt++;
                if (cnt >= lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    cnt        = 0;
                    if (rand_lat) lat = $urandom_range(1, 4);
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                end
            end else begin
                imem_ack = 1'b0;
                cnt      = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_update();
    endtask

    task automatic clear_br();
        br_valid    = 1'b0;
        branch_type = 2'b00;
        br_reg1     = '0;
        br_reg2     = '0;
        br_imm      = '0;
        br_pc       = '0;
    endtask

    task automatic do_reset(input int latency);
        rst      = 1'b1;
        freeze   = 1'b0;
        clear_br();
        mem_auto = 1'b1;
        rand_lat = 1'b0;
        lat      = latency;
        cnt      = 0;
        imem_ack = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input logic [31:0] exp_pc);
        int k;
        k = 0;
        while (!if_id_valid && k < 20) begin
            tick();
            k++;
        end
        chk({nm, "_seen"}, {31'd0, if_id_valid}, 32'd1);
        chk({nm, "_pc"}, if_id_pc, exp_pc + 32'd4);
        chk({nm, "_instr"}, if_id_instr, mem_word(exp_pc));
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        tk;
        logic        p_req, p_ack;
        logic [31:0] p_addr;
        int          n_instr;
        int          k;

        tbl[0] = '{1'b0, 1'b1, 2'b10, 32'd5, 32'd7, 16'd3,     32'h10,  1'b1, 32'h1C};
        tbl[1] = '{1'b0, 1'b1, 2'b01, 32'd1, 32'd0, 16'd4,     32'h30,  1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 2'b11, 32'd0, 32'd0, 16'hFFFE,  32'h20,  1'b1, 32'h18};
        tbl[3] = '{1'b0, 1'b1, 2'b01, 32'd0, 32'd3, 16'h7FFF,  32'h0,   1'b1, 32'h0001_FFFC};
        tbl[4] = '{1'b0, 1'b1, 2'b10, 32'd9, 32'd9, 16'd5,     32'h40,  1'b0, 32'h0};
        tbl[5] = '{1'b0, 1'b1, 2'b00, 32'd0, 32'd1, 16'd5,     32'h40,  1'b0, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 2'b11, 32'd0, 32'd0, 16'd5,     32'h40,  1'b0, 32'h0};
        tbl[7] = '{1'b1, 1'b1, 2'b11, 32'd0, 32'd0, 16'd5,     32'h40,  1'b0, 32'h0};
        tbl[8] = '{1'b0, 1'b1, 2'b11, 32'd0, 32'd0, 16'hFFF8,  32'h10,  1'b1, 32'hFFFF_FFF0};
        tbl[9] = '{1'b0, 1'b1, 2'b10, 32'd0, 32'd1, 16'd0,     32'h100, 1'b1, 32'h100};

        // Sequential fetch, latency 1
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) begin
                chk("s1_req", {31'd0, imem_req}, 32'd1);
                chk("s1_addr", imem_addr, 32'(4 * i));
            end
            if (i >= 1) begin
                chk("s1_ifid_pc", if_id_pc, 32'(4 * i));
                chk("s1_ifid_instr", if_id_instr, mem_word(32'(4 * (i - 1))));
                chk("s1_ifid_valid", {31'd0, if_id_valid}, 32'd1);
            end
        end

        // Freeze with ack arriving: B parks in the hold buffer
        do_reset(1);
        tick();
        tick();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2_req_held", {31'd0, imem_req}, 32'd0);
            chk("s2_ifid_a", if_id_instr, mem_word(32'd0));
        end
        freeze = 1'b0;
        tick();
        chk("s2_ifid_b", if_id_instr, mem_word(32'd4));
        chk("s2_ifid_b_pc", if_id_pc, 32'd8);
        chk("s2_ifid_b_valid", {31'd0, if_id_valid}, 32'd1);
        chk("s2_req_resume", {31'd0, imem_req}, 32'd1);
        chk("s2_addr_resume", imem_addr, 32'd8);

        // Branch vector table
        do_reset(1);
        tick();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            freeze      = tbl[i].frz;
            br_valid    = tbl[i].bv;
            branch_type = tbl[i].bt;
            br_reg1     = tbl[i].r1;
            br_reg2     = tbl[i].r2;
            br_imm      = tbl[i].imm;
            br_pc       = tbl[i].bpc;
            tick();
            chk($sformatf("tbl%0d_flush", i), {31'd0, flush}, {31'd0, tbl[i].exp_flush});
            freeze = 1'b0;
            clear_br();
            if (tbl[i].exp_flush) begin
                chk($sformatf("tbl%0d_valid", i), {31'd0, if_id_valid}, 32'd0);
                chk($sformatf("tbl%0d_nop", i), if_id_instr, 32'd0);
                chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_tgt);
                tick();
                chk($sformatf("tbl%0d_resume_pc", i), if_id_pc, tbl[i].exp_tgt + 32'd4);
                chk($sformatf("tbl%0d_resume_instr", i), if_id_instr, mem_word(tbl[i].exp_tgt));
            end else begin
                tick();
            end
            tick();
        end

        // Taken branch while a latency-4 request is outstanding
        do_reset(4);
        tick();
        br_valid    = 1'b1;
        branch_type = 2'b11;
        br_imm      = 16'd8;
        br_pc       = 32'h40;
        tick();
        clear_br();
        chk("s5_flush", {31'd0, flush}, 32'd1);
        chk("s5_req_held", {31'd0, imem_req}, 32'd1);
        chk("s5_addr_held", imem_addr, 32'd0);
        k = 0;
        while (imem_addr != 32'h60 && k < 20) begin
            tick();
            if (if_id_valid) chk("s5_old_data_dropped", {31'd0, if_id_valid}, 32'd0);
            k++;
        end
        chk("s5_addr_target", imem_addr, 32'h60);
        wait_valid("s5_target", 32'h60);

        // Reset during an outstanding fetch, then a late ack
        do_reset(4);
        tick();
        tick();
        mem_auto = 1'b0;
        imem_ack = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        chk("s6_rst_req", {31'd0, imem_req}, 32'd0);
        chk("s6_rst_valid", {31'd0, if_id_valid}, 32'd0);
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("s6_idle_ack_req", {31'd0, imem_req}, 32'd1);
        chk("s6_idle_ack_addr", imem_addr, 32'd0);
        chk("s6_idle_ack_valid", {31'd0, if_id_valid}, 32'd0);
        imem_ack = 1'b0;
        tick();
        chk("s6_no_late_data", {31'd0, if_id_valid}, 32'd0);
        mem_auto = 1'b1;
        lat      = 1;
        cnt      = 0;
        mem_update();
        wait_valid("s6_first", 32'd0);

        // Randomized run against a program-order reference
        do_reset(1);
        rand_lat = 1'b1;
        exp_pc   = 32'd0;
        n_instr  = 0;
        for (int c = 0; c < 3000; c++) begin
            freeze      = ($urandom_range(0, 3) == 0);
            br_valid    = ($urandom_range(0, 7) == 0);
            branch_type = 2'($urandom);
            br_reg1     = $urandom_range(0, 2);
            br_reg2     = $urandom_range(0, 2);
            br_imm      = 16'($urandom_range(0, 63) - 32);
            br_pc       = $urandom & 32'h0000_FFFC;
            tk = br_valid && !freeze &&
                 ((branch_type == 2'b01 && br_reg1 == 0) ||
                  (branch_type == 2'b10 && br_reg1 != br_reg2) ||
                  (branch_type == 2'b11));
            tgt    = br_pc + 32'(int'($signed(br_imm)) * 4);
            p_req  = imem_req;
            p_ack  = imem_ack;
            p_addr = imem_addr;
            tick();
            chk("rnd_flush", {31'd0, flush}, {31'd0, tk});
            if (p_req && !p_ack) begin
                chk("rnd_req_stable", {31'd0, imem_req}, 32'd1);
                chk("rnd_addr_stable", imem_addr, p_addr);
            end
            if (!freeze) begin
                if (tk) begin
                    chk("rnd_squash", {31'd0, if_id_valid}, 32'd0);
                    exp_pc = tgt;
                end else if (if_id_valid) begin
                    chk("rnd_pc", if_id_pc, exp_pc + 32'd4);
                    chk("rnd_instr", if_id_instr, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    n_instr++;
                end
            end
        end
        n_vec++;
        if (n_instr < 100) begin
            n_bad++;
            $display("FAIL rnd_progress: got %0d instructions required at least 100", n_instr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
